cell_truth_sweeper: RTL and testbench
=====================================

Name: cell_truth_sweeper

Overview:
- Parametrised, self-checking, exhaustive truth-table sweeper for N-input single-output standard cells (OAI/AOI/NAND family).
- Drives every input vector 0..2^N_IN-1 into the DUT and waits SETTLE cycles per vector.
- Compares the DUT output against a programmed expected truth table, then reports a mismatch count and pass/fail.
- Instantiated in cell-library regression harnesses. It replaces hand-written per-cell stimulus sequences.

Parameters:
- N_IN, 4, number of DUT inputs (1..8).
- SETTLE, 2, clock cycles each vector is held before sampling (>=1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  launch a sweep; honoured only in IDLE or DONE.
- abort  input  1  cancel a sweep in progress.
- tt_expected  input  2**N_IN  expected output; bit i is the expected value for input vector i.
- vec_out  output  N_IN  drives the DUT inputs; bit N_IN-1 goes to the first-listed cell pin (e.g. A of A,B,C1,C2).
- dut_out  input  1  DUT output.
- busy  output  1  high while in RUN.
- done  output  1  high from sweep completion until the next start or reset.
- pass  output  1  valid when done; high when err_count == 0.
- err_count  output  N_IN+1  number of mismatching vectors.
- first_err_vec  output  N_IN  first failing vector (see Optional Feature).

Behaviour:
- Reset (asynchronous, any state): state=IDLE; vec_out=0; busy=0; done=0; pass=0; err_count=0; first_err_vec=0; settle counter=0.
- States: IDLE, RUN, DONE.
- IDLE/DONE with start=1 at an edge:
  - go to RUN; vec_out=0; settle=0; err_count=0; first_err_vec=0; done=0; pass=0.
  - tt_expected is latched into a shadow register. Later changes to tt_expected are ignored until the next start.
- RUN, each edge, with abort=0:
  - settle != SETTLE-1: settle increments.
  - settle == SETTLE-1: dut_out is compared with shadow[vec_out]. A mismatch increments err_count. dut_out is therefore sampled exactly SETTLE edges after vec_out changed.
  - settle == SETTLE-1 and vec_out != all-ones: vec_out increments and settle resets to 0.
  - settle == SETTLE-1 and vec_out == all-ones: go to DONE; done=1; pass = (final err_count == 0), including the last comparison.
- Latency: done rises 2^N_IN*SETTLE edges after the edge that sampled start.
- abort=1 in RUN:
  - go to IDLE; vec_out=0; done stays 0; err_count holds its partial value.
  - abort has priority over a coinciding final comparison.
  - abort in IDLE or DONE has no effect.
- start while in RUN is ignored.
- start in DONE restarts immediately; there is no dead cycle.
- err_count width N_IN+1 holds the maximum count 2^N_IN without wrap.
- vec_out never wraps inside a sweep; the all-ones vector is terminal.
- busy is registered and equals (state == RUN).

Optional Feature:
- Macro: CELL_SWEEP_ERR_CAPTURE_EN.
- Defined: on the first mismatch of a sweep, first_err_vec captures vec_out. It holds until the next start or reset. Later mismatches do not overwrite it.
- Not defined: first_err_vec is constant 0. No capture register is synthesised.

Decomposition:
- Package/header cell_sweep_pkg:
  - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - SETTLE_MIN=1.
- One natural sub-module, cell_sweep_settle_ctr:
  - parametrised SETTLE counter with clear input and terminal-count output;
  - the top-level FSM and comparator use it.

Test Plan:
- OAI211 model (ZN = !((C1|C2)&A&B)), N_IN=4, SETTLE=2, tt_expected=16'h1FFF, start pulse -> done exactly 32 edges later, err_count=0, pass=1, vec_out walks 0..15 with each vector held 2 cycles.
- Same DUT, tt_expected=16'h3FFF (bit 13 wrong) -> err_count=1, pass=0; with CELL_SWEEP_ERR_CAPTURE_EN, first_err_vec=4'd13.
- DUT output stuck at 1, tt_expected=16'h1FFF -> err_count=3, pass=0; with the macro, first_err_vec=13.
- Assert rst asynchronously (between edges) at vector 7 -> all outputs 0 immediately; a new start then gives a full clean sweep with err_count=0.
- abort at vector 5 -> IDLE, vec_out=0, done=0. A start pulse during RUN has no effect. A start in DONE restarts with err_count=0 and done=0 on the next edge.
- N_IN=2, SETTLE=1, NAND2 model, tt_expected=4'b0111 -> done 4 edges after start, pass=1; flipping tt_expected mid-sweep does not change the result.

Source files
------------

// File: rtl/cell_sweep_pkg.sv
// Shared types and constants for the cell truth-table sweeper.
package cell_sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sweep_state_e;

    localparam int unsigned SETTLE_MIN = 1;

    // Width of a counter spanning 0..settle-1; never narrower than one bit.
    function automatic int unsigned settle_cnt_width(input int unsigned settle);
        return (settle > SETTLE_MIN) ? $clog2(settle) : 1;
    endfunction

endpackage

// File: rtl/cell_sweep_settle_ctr.sv
// Settle counter: counts 0..SETTLE-1 while enabled, wraps on terminal count.
module cell_sweep_settle_ctr
    import cell_sweep_pkg::*;
#(
    parameter int unsigned SETTLE = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic tc
);

    localparam int unsigned CW = settle_cnt_width(SETTLE);
    localparam logic [CW-1:0] LAST = CW'(SETTLE - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tc = (cnt_q == LAST);

    // Next count: clear wins, otherwise advance and wrap at the terminal count.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tc ? '0 : cnt_q + CW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cell_truth_sweeper.sv
// Exhaustive truth-table sweeper for N_IN-input single-output cells.
// Optional first-failure capture: define CELL_SWEEP_ERR_CAPTURE_EN.
module cell_truth_sweeper
    import cell_sweep_pkg::*;
#(
    parameter int unsigned N_IN   = 4,
    parameter int unsigned SETTLE = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [2**N_IN-1:0]   tt_expected,
    output logic [N_IN-1:0]      vec_out,
    input  logic                 dut_out,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [N_IN:0]        err_count,
    output logic [N_IN-1:0]      first_err_vec
);

    localparam logic [N_IN-1:0] VEC_LAST = {N_IN{1'b1}};

    sweep_state_e        state_q, state_d;
    logic [2**N_IN-1:0]  shadow_q, shadow_d;
    logic [N_IN-1:0]     vec_q, vec_d;
    logic [N_IN:0]       err_q, err_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;

    logic launch;
    logic mismatch;
    logic settle_tc;
    logic settle_clear;
    logic compare;

    assign launch   = start && (state_q != ST_RUN);
    assign mismatch = (dut_out != shadow_q[vec_q]);
    assign compare  = (state_q == ST_RUN) && !abort && settle_tc;

    cell_sweep_settle_ctr #(
        .SETTLE (SETTLE)
    ) u_settle (
        .clk   (clk),
        .rst   (rst),
        .clear (settle_clear),
        .en    (state_q == ST_RUN),
        .tc    (settle_tc)
    );

    // Sweep FSM next state: launch, per-vector compare, abort and completion.
    always_comb begin
        state_d      = state_q;
        shadow_d     = shadow_q;
        vec_d        = vec_q;
        err_d        = err_q;
        busy_d       = busy_q;
        done_d       = done_q;
        pass_d       = pass_q;
        settle_clear = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (abort) begin
                    // Partial error count is kept for post-mortem inspection.
                    state_d      = ST_IDLE;
                    vec_d        = '0;
                    busy_d       = 1'b0;
                    settle_clear = 1'b1;
                end else if (settle_tc) begin
                    err_d = err_q + (N_IN+1)'(mismatch);
                    if (vec_q == VEC_LAST) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_d == '0);
                    end else begin
                        vec_d = vec_q + N_IN'(1);
                    end
                end
            end
            default: begin
                if (launch) begin
                    state_d      = ST_RUN;
                    shadow_d     = tt_expected;
                    vec_d        = '0;
                    err_d        = '0;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                    pass_d       = 1'b0;
                    settle_clear = 1'b1;
                end
            end
        endcase
    end

    // FSM and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            shadow_q <= '0;
            vec_q    <= '0;
            err_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            vec_q    <= vec_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
        end
    end

`ifdef CELL_SWEEP_ERR_CAPTURE_EN
    logic [N_IN-1:0] first_q, first_d;

    // Capture only the first mismatch of a sweep (err_q is still zero then).
    always_comb begin
        first_d = first_q;
        if (launch) begin
            first_d = '0;
        end else if (compare && mismatch && (err_q == '0)) begin
            first_d = vec_q;
        end
    end

    // First-failure register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_q <= '0;
        end else begin
            first_q <= first_d;
        end
    end

    assign first_err_vec = first_q;
`else
    logic unused_compare;
    assign unused_compare = compare;
    assign first_err_vec  = '0;
`endif

    assign vec_out   = vec_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_cell_truth_sweeper.sv
// Self-checking bench for cell_truth_sweeper (default and N_IN=2/SETTLE=1 builds).
module tb_cell_truth_sweeper;

`ifdef CELL_SWEEP_ERR_CAPTURE_EN
    localparam bit CAPTURE = 1'b1;
`else
    localparam bit CAPTURE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start, abort;
    logic [15:0] tt_expected;
    logic [3:0]  vec_out;
    logic        dut_out;
    logic        busy, done, pass;
    logic [4:0]  err_count;
    logic [3:0]  first_err_vec;
    logic [15:0] dut_tt;

    logic        start2, abort2;
    logic [3:0]  tt2;
    logic [1:0]  vec2;
    logic        dut2;
    logic        busy2, done2, pass2;
    logic [2:0]  err2;
    logic [1:0]  first2;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Cell under test modelled as a lookup table indexed by the applied vector.
    assign dut_out = dut_tt[vec_out];
    // NAND2: vec bit1 = A, bit0 = B.
    assign dut2    = ~(vec2[1] & vec2[0]);

    cell_truth_sweeper #(.N_IN(4), .SETTLE(2)) u_dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .tt_expected   (tt_expected),
        .vec_out       (vec_out),
        .dut_out       (dut_out),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_count     (err_count),
        .first_err_vec (first_err_vec)
    );

    cell_truth_sweeper #(.N_IN(2), .SETTLE(1)) u_dut2 (
        .clk           (clk),
        .rst           (rst),
        .start         (start2),
        .abort         (abort2),
        .tt_expected   (tt2),
        .vec_out       (vec2),
        .dut_out       (dut2),
        .busy          (busy2),
        .done          (done2),
        .pass          (pass2),
        .err_count     (err2),
        .first_err_vec (first2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // OAI211 ZN = !((C1|C2)&A&B) with vec bits {A,B,C1,C2}.
    function automatic logic [15:0] oai211_tt();
        logic [15:0] t;
        for (int i = 0; i < 16; i++) begin
            logic a, b, c1, c2;
            a  = i[3];
            b  = i[2];
            c1 = i[1];
            c2 = i[0];
            t[i] = !((c1 | c2) & a & b);
        end
        return t;
    endfunction

    // Reference: count differing vectors among the first `upto`, note the lowest.
    task automatic model(input logic [15:0] tt, input logic [15:0] dt, input int upto,
                         output int errs, output int first);
        errs  = 0;
        first = 0;
        for (int i = 0; i < upto; i++) begin
            if (tt[i] !== dt[i]) begin
                if (errs == 0) first = i;
                errs++;
            end
        end
    endtask

    task automatic run_sweep(input string tag, input logic [15:0] tt, input bit flip,
                             input bit poke);
        int errs, first, exp_first;
        model(tt, dut_tt, 16, errs, first);
        exp_first   = CAPTURE ? first : 0;
        tt_expected = tt;
        start       = 1'b1;
        step();
        start = 1'b0;
        check({tag, "/launch_busy"}, busy, 1);
        check({tag, "/launch_done"}, done, 0);
        check({tag, "/launch_err"}, err_count, 0);
        check({tag, "/launch_vec"}, vec_out, 0);
        for (int k = 1; k <= 32; k++) begin
            if (flip && k == 3) tt_expected = ~tt;
            start = poke && (k == 5);
            step();
            start = 1'b0;
            if (k < 32) begin
                check({tag, "/walk_vec"}, vec_out, k / 2);
                check({tag, "/walk_done"}, done, 0);
            end
        end
        check({tag, "/done"}, done, 1);
        check({tag, "/busy"}, busy, 0);
        check({tag, "/err"}, err_count, errs);
        check({tag, "/pass"}, pass, (errs == 0) ? 1 : 0);
        check({tag, "/first"}, first_err_vec, exp_first);
        check({tag, "/vec_end"}, vec_out, 15);
        tt_expected = tt;
    endtask

    task automatic wait_vec(input string tag, input int target);
        int n = 0;
        while (vec_out != target && n < 100) begin
            step();
            n++;
        end
        check({tag, "/reached"}, vec_out, target);
    endtask

    initial begin
        int errs, first;
        rst         = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
        tt_expected = 16'h1FFF;
        dut_tt      = oai211_tt();
        start2      = 1'b0;
        abort2      = 1'b0;
        tt2         = 4'b0111;
        step();
        step();
        check("rst/vec", vec_out, 0);
        check("rst/busy", busy, 0);
        check("rst/done", done, 0);
        check("rst/pass", pass, 0);
        check("rst/err", err_count, 0);
        check("rst/first", first_err_vec, 0);
        check("rst2/done", done2, 0);
        check("rst2/vec", vec2, 0);
        rst = 1'b0;
        step();

        // Abort while idle does nothing.
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("idle_abort/busy", busy, 0);
        check("idle_abort/done", done, 0);

        // Good OAI211 with a start pulse injected mid-run.
        run_sweep("oai_ok", 16'h1FFF, 1'b0, 1'b1);

        // Abort in DONE has no effect.
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("done_abort/done", done, 1);
        check("done_abort/pass", pass, 1);

        // Restart directly from DONE with a wrong expectation at vector 13.
        run_sweep("oai_bit13", 16'h3FFF, 1'b0, 1'b0);
        dut_tt = 16'hFFFF;
        run_sweep("stuck1", 16'h1FFF, 1'b0, 1'b0);

        // Asynchronous reset between edges at vector 7.
        dut_tt      = oai211_tt() ^ 16'h0006;
        tt_expected = 16'h1FFF;
        start       = 1'b1;
        step();
        start = 1'b0;
        wait_vec("arst", 7);
        #2 rst = 1'b1;
        #1;
        check("arst/vec", vec_out, 0);
        check("arst/busy", busy, 0);
        check("arst/done", done, 0);
        check("arst/pass", pass, 0);
        check("arst/err", err_count, 0);
        check("arst/first", first_err_vec, 0);
        #1 rst = 1'b0;
        step();
        dut_tt = oai211_tt();
        run_sweep("after_rst", 16'h1FFF, 1'b0, 1'b0);

        // Abort at vector 5 keeps the partial count of vectors 0..4.
        dut_tt = oai211_tt() ^ 16'h0015;
        model(16'h1FFF, dut_tt, 5, errs, first);
        tt_expected = 16'h1FFF;
        start       = 1'b1;
        step();
        start = 1'b0;
        wait_vec("abort", 5);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort/busy", busy, 0);
        check("abort/vec", vec_out, 0);
        check("abort/done", done, 0);
        check("abort/err", err_count, errs);
        step();
        check("abort/idle_vec", vec_out, 0);
        check("abort/idle_busy", busy, 0);

        // Randomised cells and expectations, half with a mid-sweep tt change.
        for (int r = 0; r < 6; r++) begin
            logic [15:0] tt;
            dut_tt = 16'($urandom);
            tt     = (r % 3 == 0) ? dut_tt : 16'($urandom);
            run_sweep("rand", tt, r[0], r[1]);
        end

        // Small instance: NAND2, settle 1; tt changes mid-sweep are ignored.
        tt2    = 4'b0111;
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        check("nand2/busy", busy2, 1);
        for (int k = 1; k <= 4; k++) begin
            if (k == 2) tt2 = 4'b1000;
            step();
            if (k < 4) check("nand2/walk_done", done2, 0);
        end
        check("nand2/done", done2, 1);
        check("nand2/pass", pass2, 1);
        check("nand2/err", err2, 0);
        check("nand2/vec", vec2, 3);
        check("nand2/first", first2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
